led_matrix_scan: RTL and testbench

Row-scanning serial driver for the 8x16 two-colour LED note matrix. It consumes the note-window interface produced by the song scroller (`note_R`, `note_B`, `offset`) and renders the scrolling note track plus a fixed judge marker. It snapshots these inputs once per frame, so frames never tear. It shifts each row out over a 74HC595-style serial bus (`ser_r`, `ser_b`, `sclk`, `latch`), selects the row through `row_sel`, and gates brightness with `oe_n`.

---
 rtl/led_matrix_scan_if.sv | 8 +
 rtl/led_matrix_scan.sv | 129 ++++++++++++
 tb/tb_led_matrix_scan.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/led_matrix_scan_if.sv
// led_matrix_scan_if: note-window bus from the song scroller to the matrix scanner
interface led_matrix_scan_if;
  logic [9:0] note_R;
  logic [9:0] note_B;
  logic [3:0] offset;
  modport master(output note_R, note_B, offset);
  modport slave(input note_R, note_B, offset);
endinterface

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: row-scanning serial driver for the 8x16 two-colour note matrix
module led_matrix_scan #(
  parameter int NOTE_W    = 3,
  parameter int JUDGE_COL = 1,
  parameter int DWELL_CYC = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  led_matrix_scan_if.slave    nw,
  output logic                ser_r,
  output logic                ser_b,
  output logic                sclk,
  output logic                latch,
  output logic [2:0]          row_sel,
  output logic                oe_n,
  output logic                frame_done
);
  localparam int CW = $clog2(DWELL_CYC + 32);
  typedef enum logic [2:0] {IDLE, SNAP, SHIFT, LATCH, DWELL} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] r_q, r_d, off_q, off_d, row_sel_q, row_sel_d;
  logic [9:0] nr_q, nr_d, nb_q, nb_d;
  logic ser_r_q, ser_r_d, ser_b_q, ser_b_d, sclk_q, sclk_d, latch_q, latch_d;
  logic oe_n_q, oe_n_d, frame_done_q, frame_done_d;
  logic [1:0] px;

  function automatic logic [1:0] pix(input logic [2:0] r, input logic [3:0] c,
                                     input logic [2:0] off, input logic [9:0] nr, input logic [9:0] nb);
    logic [4:0] p;
    logic [1:0] slot;
    logic [2:0] ph;
    logic note, judge;
    p     = {1'b0, c} + {2'b0, off};
    slot  = 2'(p / 5'd7);
    ph    = 3'(p % 5'd7);
    note  = r >= 3'd2 && r <= 3'd5 && ph < 3'(NOTE_W);
    judge = (r == 3'd1 || r == 3'd6) && c == 4'(JUDGE_COL);
    return {(note & nr[slot]) | judge, (note & nb[slot]) | judge};
  endfunction

  // Next-state, snapshot and registered-output computation; outputs are derived from next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    nr_d    = nr_q;
    nb_d    = nb_q;
    off_d   = off_q;
    case (state_q)
      IDLE:  if (enable) state_d = SNAP;
      SNAP: begin
        nr_d    = nw.note_R;
        nb_d    = nw.note_B;
        off_d   = nw.offset > 4'd6 ? 3'd6 : nw.offset[2:0];
        r_d     = 3'd0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(31)) begin
          cnt_d   = '0;
          state_d = LATCH;
        end
      end
      LATCH: state_d = DWELL;
      DWELL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DWELL_CYC - 1)) begin
          cnt_d   = '0;
          r_d     = r_q + 3'd1;
          state_d = r_q == 3'd7 ? (enable ? SNAP : IDLE) : SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
    px           = pix(r_d, 4'd15 - cnt_d[4:1], off_d, nr_d, nb_d);
    ser_r_d      = state_d == SHIFT && px[1];
    ser_b_d      = state_d == SHIFT && px[0];
    sclk_d       = state_d == SHIFT && cnt_d[0];
    latch_d      = state_d == LATCH;
    row_sel_d    = state_d == LATCH ? r_d : row_sel_q;
    oe_n_d       = state_d != DWELL;
    frame_done_d = state_d == DWELL && r_d == 3'd7 && cnt_d == CW'(DWELL_CYC - 1);
  end

  // State, snapshot and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      r_q          <= '0;
      off_q        <= '0;
      nr_q         <= '0;
      nb_q         <= '0;
      ser_r_q      <= 1'b0;
      ser_b_q      <= 1'b0;
      sclk_q       <= 1'b0;
      latch_q      <= 1'b0;
      row_sel_q    <= '0;
      oe_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      r_q          <= r_d;
      off_q        <= off_d;
      nr_q         <= nr_d;
      nb_q         <= nb_d;
      ser_r_q      <= ser_r_d;
      ser_b_q      <= ser_b_d;
      sclk_q       <= sclk_d;
      latch_q      <= latch_d;
      row_sel_q    <= row_sel_d;
      oe_n_q       <= oe_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ser_r      = ser_r_q;
  assign ser_b      = ser_b_q;
  assign sclk       = sclk_q;
  assign latch      = latch_q;
  assign row_sel    = row_sel_q;
  assign oe_n       = oe_n_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: scoreboard bench capturing each shifted row and checking it at latch
module tb_led_matrix_scan;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic ser_r, ser_b, sclk, latch, oe_n, frame_done;
  logic [2:0] row_sel;
  led_matrix_scan_if nw();
  led_matrix_scan dut (
    .clk(clk), .rst(rst), .enable(enable), .nw(nw),
    .ser_r(ser_r), .ser_b(ser_b), .sclk(sclk), .latch(latch),
    .row_sel(row_sel), .oe_n(oe_n), .frame_done(frame_done)
  );
  always #5 clk = ~clk;

  typedef struct packed {logic [2:0] row; logic [15:0] r; logic [15:0] b;} row_t;
  row_t sb[$];
  int checks = 0, failures = 0, cyc = 0, fd_cnt = 0;
  int fd_t[$];
  logic [15:0] last_r[8], last_b[8];

  function automatic row_t model(int row, logic [9:0] nr, logic [9:0] nb, int off);
    row_t e;
    e.row = row[2:0];
    e.r = '0;
    e.b = '0;
    for (int c = 0; c < 16; c++) begin
      int p = c + off;
      int slot = p / 7;
      int ph = p % 7;
      bit note = row >= 2 && row <= 5 && ph < 3;
      bit judge = (row == 1 || row == 6) && c == 1;
      e.r[c] = (note && nr[slot]) || judge;
      e.b[c] = (note && nb[slot]) || judge;
    end
    return e;
  endfunction

  task automatic push_frame(logic [9:0] nr, logic [9:0] nb, int off);
    for (int r = 0; r < 8; r++) sb.push_back(model(r, nr, nb, off));
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [15:0] cr = '0, cb = '0;
    int ns = 0;
    logic ps = 1'b0;
    row_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        ns = 0;
        ps = 1'b0;
      end else begin
        if (frame_done) begin
          fd_cnt++;
          fd_t.push_back(cyc);
        end
        if (sclk && !ps) begin
          cr = {cr[14:0], ser_r};
          cb = {cb[14:0], ser_b};
          ns++;
        end
        if (latch) begin
          chk("sb_nonempty", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("row_sel", 32'(row_sel), 32'(e.row));
            chk($sformatf("red_row%0d", e.row), 32'(cr), 32'(e.r));
            chk($sformatf("blue_row%0d", e.row), 32'(cb), 32'(e.b));
            chk("shift_bits", ns, 16);
            chk("oe_n_at_latch", 32'(oe_n), 1);
            last_r[e.row] = cr;
            last_b[e.row] = cb;
          end
          ns = 0;
        end
        ps = sclk;
      end
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(int n);
    int s, i;
    s = fd_cnt;
    i = 0;
    while (fd_cnt == s && i < n) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk("frame_done_seen", 32'(fd_cnt > s), 1);
  endtask

  task automatic run_frame(logic [9:0] nr, logic [9:0] nb, logic [3:0] off, int exp_off);
    nw.note_R = nr;
    nw.note_B = nb;
    nw.offset = off;
    push_frame(nr, nb, exp_off);
    enable = 1'b1;
    tick(3);
    enable = 1'b0;
    wait_fd(2500);
    tick(5);
    chk("idle_oe_n", 32'(oe_n), 1);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int i;
    logic seen_low;
    nw.note_R = '0;
    nw.note_B = '0;
    nw.offset = '0;
    fork monitor(); join_none
    tick(3);
    chk("rst_oe_n", 32'(oe_n), 1);
    chk("rst_outs", 32'({ser_r, ser_b, sclk, latch, row_sel, frame_done}), 0);
    rst = 1'b0;
    tick(2);
    run_frame(10'h001, 10'h000, 4'd0, 0);
    chk("f1_r2", 32'(last_r[2]), 32'h0007);
    chk("f1_b2", 32'(last_b[2]), 32'h0000);
    chk("f1_r0", 32'(last_r[0]), 32'h0000);
    chk("f1_r1_judge", 32'(last_r[1]), 32'h0002);
    chk("f1_b6_judge", 32'(last_b[6]), 32'h0002);
    run_frame(10'h002, 10'h000, 4'd4, 4);
    chk("f2_r3", 32'(last_r[3]), 32'h0038);
    chk("f2_r5", 32'(last_r[5]), 32'h0038);
    run_frame(10'h002, 10'h000, 4'd9, 6);
    chk("f3_off9_as6", 32'(last_r[2]), 32'h000E);
    nw.note_R = 10'h000;
    nw.note_B = 10'h00F;
    nw.offset = 4'd0;
    push_frame(10'h000, 10'h00F, 0);
    enable = 1'b1;
    tick(3);
    nw.note_R = 10'h3FF;
    nw.note_B = 10'h000;
    nw.offset = 4'd3;
    push_frame(10'h3FF, 10'h000, 3);
    wait_fd(2500);
    chk("f4_b2", 32'(last_b[2]), 32'hC387);
    chk("f4_b4", 32'(last_b[4]), 32'hC387);
    chk("f4_r3_unchanged", 32'(last_r[3]), 32'h0000);
    i = 0;
    while (!(row_sel == 3'd3 && !oe_n) && i < 2000) begin
      tick(1);
      i++;
    end
    chk("reached_row3", 32'(row_sel), 3);
    enable = 1'b0;
    wait_fd(2500);
    chk("fd_period", fd_t[$] - fd_t[$-1], 1865);
    chk("f5_r3", 32'(last_r[3]), 32'h3870);
    seen_low = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      seen_low |= !oe_n;
    end
    chk("parked_oe_n_low_seen", 32'(seen_low), 0);
    chk("parked_sb", sb.size(), 0);
    nw.note_R = 10'h001;
    nw.note_B = 10'h000;
    nw.offset = 4'd0;
    push_frame(10'h001, 10'h000, 0);
    enable = 1'b1;
    i = 0;
    while (!(row_sel == 3'd4 && !oe_n) && i < 3000) begin
      tick(1);
      i++;
    end
    chk("reached_row4_dwell", 32'({row_sel, oe_n}), 32'({3'd4, 1'b0}));
    #2 rst = 1'b1;
    #1;
    chk("midrst_oe_n", 32'(oe_n), 1);
    chk("midrst_outs", 32'({ser_r, ser_b, sclk, latch, row_sel, frame_done}), 0);
    sb.delete();
    nw.note_R = 10'h000;
    nw.note_B = 10'h3FF;
    nw.offset = 4'd5;
    push_frame(10'h000, 10'h3FF, 5);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    chk("snap_sclk", 32'({sclk, oe_n}), 32'({1'b0, 1'b1}));
    tick(1);
    chk("phase0_sclk", 32'({sclk, oe_n}), 32'({1'b0, 1'b1}));
    tick(1);
    chk("first_sclk_rise", 32'({sclk, oe_n}), 32'({1'b1, 1'b1}));
    enable = 1'b0;
    wait_fd(2500);
    tick(5);
    chk("post_rst_b2", 32'(last_b[2]), 32'h0E1C);
    chk("post_rst_b1", 32'(last_b[1]), 32'h0002);
    chk("post_rst_sb", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
